// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : State encoding and default 50 MHz timing for key_debounce.
// Revision : 1.0
// ============================================================================
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_LONG_CYC     = 50_000_000;
  localparam int DEF_REPEAT_CYC   = 10_000_000;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for a single asynchronous input bit.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Debounces one active-low push-button into level, press, release,
//            long-hold and auto-repeat events (all registered).
// Revision : 1.0
// ============================================================================
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(LONG_CYC);
  localparam int REP_W  = $clog2(REPEAT_CYC);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

  logic sync_key_n;
  logic key_s;

  key_state_e        state_q,     state_d;
  logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q,   rep_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q,     level_d;
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              long_q,      long_d;
  logic              repeat_q,    repeat_d;

  // Resets to "released" so a reset never fabricates a press.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_key (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (sync_key_n)
  );

  assign key_s = ~sync_key_n;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_s) begin
          state_d  = ST_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!key_s) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_HELD;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (!key_s) begin
          state_d  = ST_RELEASE_DB;
          db_cnt_d = '0;
        end else if (!long_done_q) begin
          // hold_cnt parks at its last value once the long event has fired
          if (hold_cnt_q == HOLD_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            rep_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end else if (rep_cnt_q == REP_LAST) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      ST_RELEASE_DB: begin
        if (key_s) begin
          state_d = ST_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce
// Purpose  : Directed and random stimulus for key_debounce against a
//            run-length reference model.
// Revision : 1.0
// ============================================================================
module tb_key_debounce;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic key_n = 1'b1;
  logic key_level, key_press, key_release, key_long, key_repeat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  key_debounce #(
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .REPEAT_CYC   (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_repeat  (key_repeat)
  );

  always #5 clk = ~clk;

  // Reference model: the level flips after D+1 consecutive opposite samples
  // (seen two edges late); events are counted in qualifying held samples.
  bit   hist[$] = '{1'b1, 1'b1};
  bit   m_s;
  bit   m_prev  = 1'b0;
  bit   m_lvl   = 1'b0;
  int   m_run   = 0;
  int   m_held  = 0;
  logic e_level = 1'b0, e_press = 1'b0, e_release = 1'b0, e_long = 1'b0, e_repeat = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist = '{1'b1, 1'b1};
      m_prev = 1'b0; m_lvl = 1'b0; m_run = 0; m_held = 0;
      e_level = 1'b0; e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
    end else begin
      m_s = !hist.pop_front();
      hist.push_back(key_n);
      e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
      if (m_s != m_lvl) m_run++;
      else              m_run = 0;
      if (m_run == D + 1) begin
        m_lvl = m_s;
        m_run = 0;
        if (m_s) begin e_press = 1'b1; m_held = 0; end
        else     e_release = 1'b1;
      end else if (m_lvl && m_s && m_prev) begin
        m_held++;
        if (m_held == L) e_long = 1'b1;
        else if (m_held > L && (m_held - L) % R == 0) e_repeat = 1'b1;
      end
      m_prev  = m_s;
      e_level = m_lvl;
    end
  end

  int n_press = 0, n_release = 0, n_long = 0;
  int press_cyc = -1, release_cyc = -1, long_cyc = -1;
  int rep_cycs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"},   32'(key_level),   32'd0);
    chk({tag, "_press"},   32'(key_press),   32'd0);
    chk({tag, "_release"}, 32'(key_release), 32'd0);
    chk({tag, "_long"},    32'(key_long),    32'd0);
    chk({tag, "_repeat"},  32'(key_repeat),  32'd0);
  endtask

  task automatic cycle(input logic kn);
    key_n = kn;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("level",   32'(key_level),   32'(e_level));
    chk("press",   32'(key_press),   32'(e_press));
    chk("release", 32'(key_release), 32'(e_release));
    chk("long",    32'(key_long),    32'(e_long));
    chk("repeat",  32'(key_repeat),  32'(e_repeat));
    if (key_press)   begin n_press++;   press_cyc   = cyc; end
    if (key_release) begin n_release++; release_cyc = cyc; end
    if (key_long)    begin n_long++;    long_cyc    = cyc; end
    if (key_repeat)  rep_cycs.push_back(cyc);
  endtask

  int c0, cf, p, rr, np, nr, nl;
  bit lv;
  int len;

  initial begin
    // 1: reset with key pressed, then press latency
    #1 rst = 1'b1; key_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check_zero("t1_reset");
    rst = 1'b0;
    c0 = cyc + 1;
    repeat (10) cycle(1'b0);
    chk("t1_press_cyc", press_cyc, c0 + 6);
    chk("t1_n_press", n_press, 1);
    repeat (10) cycle(1'b1);

    // 2: short glitch is rejected
    np = n_press; nr = n_release;
    repeat (3) cycle(1'b0);
    repeat (10) cycle(1'b1);
    chk("t2_n_press", n_press, np);
    chk("t2_n_release", n_release, nr);

    // 3: bouncing press, then 4: long hold with repeats and release
    np = n_press; nl = n_long;
    rep_cycs.delete();
    for (int i = 0; i < 12; i++) cycle(logic'((i / 2) % 2));
    cf = cyc + 1;
    repeat (7) cycle(1'b0);
    chk("t3_n_press", n_press, np + 1);
    chk("t3_press_cyc", press_cyc, cf + 6);
    p = press_cyc;
    while (cyc < p + 41) cycle(1'b0);
    rr = cyc + 1;
    repeat (10) cycle(1'b1);
    chk("t4_n_long", n_long, nl + 1);
    chk("t4_long_cyc", long_cyc, p + 20);
    chk("t4_n_repeat", rep_cycs.size(), 4);
    foreach (rep_cycs[k]) chk("t4_repeat_cyc", rep_cycs[k], p + 25 + 5 * k);
    chk("t4_release_cyc", release_cyc, rr + 6);

    // 5: short release glitch while held
    repeat (8) cycle(1'b0);
    np = n_press; nr = n_release;
    repeat (2) cycle(1'b1);
    repeat (8) cycle(1'b0);
    chk("t5_n_press", n_press, np);
    chk("t5_n_release", n_release, nr);
    chk("t5_level", 32'(key_level), 32'd1);

    // 6: reset while held
    #2 rst = 1'b1;
    #1 check_zero("t6_reset");
    @(negedge clk);
    rst = 1'b0;
    np = n_press; nr = n_release;
    c0 = cyc + 1;
    repeat (10) cycle(1'b0);
    chk("t6_n_press", n_press, np + 1);
    chk("t6_press_cyc", press_cyc, c0 + 6);
    chk("t6_n_release", n_release, nr);

    // random runs of pressed/released with assorted lengths
    for (int k = 0; k < 40; k++) begin
      lv  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      repeat (len) cycle(lv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
